clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
Parametrised multi-channel programmable clock divider. It is the successor to the fixed divide-by-24 divider. Each channel produces a registered divided-clock enable waveform with runtime-programmable period and high time, and a period-start tick. It sits in the PE clocking/timing layer, feeding slow strobes to downstream PE logic. Reprogramming is glitch-free through shadow registers, and a shared sync clear realigns all channels.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 8, width of counter, divisor and high-time fields
DEF_DIV, 11, reset divisor field (period = DEF_DIV+1 = 12 cycles)
DEF_HIGH, 6, reset high-time field (cycles high per period)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global count enable; 0 freezes all channels
sync_clr  input  1  synchronous restart of all channels at period start
cfg_we  input  1  configuration write strobe
cfg_ch  input  3  target channel index for cfg_we
cfg_div  input  CNT_W  divisor field; period = cfg_div+1 cycles
cfg_high  input  CNT_W  high-time field in cycles
div_out  output  NUM_CH  registered divided waveform per channel
tick  output  NUM_CH  one-cycle pulse when a channel's period restarts
cfg_pending  output  NUM_CH  shadow written but not yet applied

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state is in flops.
- Reset values per channel: cnt=0, div_a=div_s=DEF_DIV, high_a=high_s=DEF_HIGH, cfg_pending=0, div_out=0, tick=0.
- Counting, per clk edge with en=1 and sync_clr=0:
  - If cnt==div_a (wrap): cnt<=0; tick<=1. If pending, the shadow is copied to the active registers (div_a<=div_s, high_a<=high_s) and cfg_pending<=0.
  - Otherwise: cnt<=cnt+1; tick<=0.
- div_out<=(cnt_next < high_a_next), using the post-edge count and active values.
  - high_a=0: always low.
  - high_a>div_a: always high.
  - div_a=0: period is 1 cycle; tick stays high continuously while enabled.
- After reset, div_out reads 0 until the first enabled edge, even if DEF_HIGH>0.
- en=0 and sync_clr=0: cnt, active registers and div_out hold; tick<=0. The config shadow path still works.
- sync_clr=1 (priority over en, all channels):
  - cnt<=0; tick<=1.
  - Pending shadow is applied and cfg_pending cleared.
  - div_out<=(0 < high_a_next).
- Config writes:
  - cfg_we=1 with cfg_ch<NUM_CH: div_s<=cfg_div, high_s<=cfg_high, cfg_pending[cfg_ch]<=1.
  - cfg_ch>=NUM_CH: write ignored, no state change.
  - Repeated writes before the apply point overwrite the shadow; only the last value is applied.
- Write in the same cycle as a wrap or sync_clr on that channel:
  - The apply uses the pre-write shadow, and only if pending was already 1.
  - The new write lands in the shadow with cfg_pending=1 and applies at the next wrap or sync_clr.
- Active period never changes mid-period; latency from write to effect is at most one full remaining period plus one cycle.
- Arithmetic: cnt is CNT_W bits; comparisons are unsigned. No overflow, because cnt never exceeds div_a.
- Reset asserted mid-operation immediately forces all reset values, discarding shadow and pending state.

Test Plan:
- Reset, en=1 held, defaults → each channel: div_out 6 cycles high, 6 low; tick every 12 cycles, coincident with div_out rising.
- Mid-period write ch1 div=4 high=2 → ch1 completes its current 12-cycle period, cfg_pending[1]=1 until the wrap. Then 5-cycle periods (2 high/3 low); ch0 unaffected.
- Write high=0, then high=20 with div=9 → after apply, div_out constantly 0, then constantly 1; tick every 10 cycles in both cases.
- Channels desynchronised by staggered writes, then sync_clr pulse → next cycle both ticks=1 and both counters at 0; waveforms aligned thereafter.
- en low for 7 cycles mid-high phase → div_out and count frozen, tick=0; resumes exactly where it stopped. cfg_we during freeze sets pending without applying.
- cfg_we on the exact wrap cycle with prior pending shadow A, writing B → A applied at that wrap, B applied at the following wrap. cfg_ch=5 write → ignored. rst_n pulsed mid-period → all outputs 0, defaults restored.

Source files
------------

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel programmable clock divider with shadowed
// period/high-time config applied only at period start or on sync_clr.
module clock_divider_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 11,
    parameter int DEF_HIGH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt, div_a, div_s, high_a, high_s;
        logic [CNT_W-1:0] cnt_n, div_n, high_n;
        logic             pend, out_q, tick_q, restart, apply, wr;
        always_comb begin
            restart = sync_clr | (en & (cnt == div_a));
            apply   = restart & pend;
            wr      = cfg_we & (cfg_ch == 3'(g));
            div_n   = apply ? div_s : div_a;
            high_n  = apply ? high_s : high_a;
            cnt_n   = restart ? '0 : en ? cnt + 1'b1 : cnt;
        end
        // apply reads the shadow before a same-cycle write lands in it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div_a  <= CNT_W'(DEF_DIV);
                div_s  <= CNT_W'(DEF_DIV);
                high_a <= CNT_W'(DEF_HIGH);
                high_s <= CNT_W'(DEF_HIGH);
                pend   <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt    <= cnt_n;
                div_a  <= div_n;
                high_a <= high_n;
                tick_q <= restart;
                pend   <= wr | (pend & ~restart);
                if (wr) begin
                    div_s  <= cfg_div;
                    high_s <= cfg_high;
                end
                if (en | sync_clr)
                    out_q <= cnt_n < high_n;
            end
        end
        assign div_out[g]     = out_q;
        assign tick[g]        = tick_q;
        assign cfg_pending[g] = pend;
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed plus random stimulus against a phase/period model.
module tb_clock_divider_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0;
    logic [2:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0, cfg_high = '0;
    logic [NUM_CH-1:0] div_out, tick, cfg_pending;

    int checks = 0, errors = 0;

    // model: phase within period, period length, high cycles, shadow copies
    int phase [NUM_CH], period [NUM_CH], high [NUM_CH], s_period [NUM_CH], s_high [NUM_CH];
    logic m_pend [NUM_CH], m_out [NUM_CH], m_tick [NUM_CH];

    clock_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(11), .DEF_HIGH(6)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .div_out(div_out), .tick(tick), .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            phase[i] = 0; period[i] = 12; high[i] = 6; s_period[i] = 12; s_high[i] = 6;
            m_pend[i] = 1'b0; m_out[i] = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic e, s, w, input int c, d, h);
        for (int i = 0; i < NUM_CH; i++) begin
            logic start;
            start = s || (e && phase[i] == period[i] - 1);
            if (start && m_pend[i]) begin
                period[i] = s_period[i]; high[i] = s_high[i]; m_pend[i] = 1'b0;
            end
            phase[i] = start ? 0 : e ? phase[i] + 1 : phase[i];
            m_tick[i] = start;
            if (e || s) m_out[i] = phase[i] < high[i];
            if (w && c == i) begin
                s_period[i] = d + 1; s_high[i] = h; m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] eo, et, ep;
        for (int i = 0; i < NUM_CH; i++) begin
            eo[i] = m_out[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
        end
        checks += 3;
        assert (div_out === eo) else begin errors++; $error("FAIL %s div_out observed %b expected %b", tag, div_out, eo); end
        assert (tick === et) else begin errors++; $error("FAIL %s tick observed %b expected %b", tag, tick, et); end
        assert (cfg_pending === ep) else begin errors++; $error("FAIL %s cfg_pending observed %b expected %b", tag, cfg_pending, ep); end
    endtask

    task automatic cyc(input string tag, input logic e, s, w, input int c, d, h);
        en = e; sync_clr = s; cfg_we = w; cfg_ch = 3'(c); cfg_div = CNT_W'(d); cfg_high = CNT_W'(h);
        @(posedge clk);
        model_step(e, s, w, c, d, h);
        #1 check_outputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12 check_outputs("reset");
        rst_n = 1'b1;
        cyc("idle_after_reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run("defaults", 30);
        cyc("write_ch1", 1'b1, 1'b0, 1'b1, 1, 4, 2);
        run("ch1_div4", 30);
        cyc("high0", 1'b1, 1'b0, 1'b1, 0, 9, 0);
        run("high0_run", 25);
        cyc("high20", 1'b1, 1'b0, 1'b1, 0, 9, 20);
        run("high20_run", 25);
        cyc("stagger0", 1'b1, 1'b0, 1'b1, 0, 6, 3);
        run("stagger_run", 3);
        cyc("stagger1", 1'b1, 1'b0, 1'b1, 1, 8, 5);
        run("stagger_run2", 20);
        cyc("sync_clr", 1'b1, 1'b1, 1'b0, 0, 0, 0);
        checks++;
        assert (tick === '1) else begin errors++; $error("FAIL sync_ticks observed %b expected %b", tick, 2'b11); end
        run("aligned", 15);
        while (!(phase[0] >= 1 && phase[0] < high[0] - 1)) cyc("seek_high", 1'b1, 1'b0, 1'b0, 0, 0, 0);
        cyc("freeze_w", 1'b0, 1'b0, 1'b1, 1, 3, 1);
        for (int k = 0; k < 6; k++) cyc("freeze", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run("resume", 20);
        cyc("shadow_a", 1'b1, 1'b0, 1'b1, 0, 4, 2);
        for (int k = 0; k < 100 && phase[0] != period[0] - 1; k++) cyc("seek_wrap", 1'b1, 1'b0, 1'b0, 0, 0, 0);
        checks++;
        assert (phase[0] == period[0] - 1) else begin errors++; $error("FAIL seek_wrap_timeout observed %0d expected %0d", phase[0], period[0] - 1); end
        cyc("shadow_b_on_wrap", 1'b1, 1'b0, 1'b1, 0, 2, 1);
        run("after_ab", 15);
        cyc("bad_ch", 1'b1, 1'b0, 1'b1, 5, 1, 1);
        run("after_bad", 10);
        cyc("pend_before_rst", 1'b1, 1'b0, 1'b1, 1, 7, 3);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("async_reset");
        @(negedge clk) rst_n = 1'b1;
        run("post_reset", 26);
        for (int k = 0; k < 400; k++)
            cyc("random", $urandom_range(99) < 85, $urandom_range(99) < 3, $urandom_range(99) < 10,
                int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(18)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
